// File: rtl/blram_arb_pkg.sv
// Shared definitions for the blram arbiter: port identifiers and lock-owner encoding.
package blram_arb_pkg;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   typedef enum logic [1:0] {
      LOCK_NONE = 2'b00,
      LOCK_P0   = 2'b01,
      LOCK_P1   = 2'b10
   } lock_owner_t;

endpackage

// File: rtl/blram_arbiter_if.sv
// Requester and memory-side signal bundle for blram_arbiter.
interface blram_arb_if #(
   parameter int SIZE = 14,
   parameter int DW   = 32
);

   logic            req0,    req1;
   logic            we0,     we1;
   logic [SIZE-1:0] addr0,   addr1;
   logic [DW-1:0]   wdata0,  wdata1;
   logic            lock0,   lock1;
   logic            gnt0,    gnt1;
   logic            rvalid0, rvalid1;
   logic [DW-1:0]   rdata0,  rdata1;
   logic            mem_we;
   logic [SIZE-1:0] mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
      output mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
      input  mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/blram_arbiter_arb2_pick.sv
// Combinational two-way picker: a lone requester wins, contention is settled by prio.
module arb2_pick
   import blram_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       prio,
   output logic       win_valid,
   output logic       win_id
);

   always_comb begin
      win_valid = |req;
      win_id    = PORT0;
      if (req == 2'b11)
         win_id = prio;
      else if (req[1])
         win_id = PORT1;
   end

endmodule

// File: rtl/blram_arbiter.sv
// Shares one single-port blram between Vscpu (port 0) and the debug/DMA loader (port 1).
// Define BLRAM_ARB_RR_EN for round-robin contention; otherwise port 0 always wins.
module blram_arbiter
   import blram_arb_pkg::*;
#(
   parameter int SIZE = 14,
   parameter int DW   = 32
) (
   input logic        clk,
   input logic        rst,
   blram_arb_if.slave bus
);

   lock_owner_t     lock_owner;
   logic [1:0]      cand;
   logic            prio;
   logic            win_valid;
   logic            win_id;
   logic            rd_pend;
   logic            rd_id;
   logic            sel_we;
   logic            sel_lock;
   logic [SIZE-1:0] sel_addr;
   logic [DW-1:0]   sel_wdata;

   // A locked owner masks the other port; reset masks both.
   always_comb begin
      cand = 2'b00;
      if (!rst) begin
         case (lock_owner)
            LOCK_P0: cand = {1'b0, bus.req0};
            LOCK_P1: cand = {bus.req1, 1'b0};
            default: cand = {bus.req1, bus.req0};
         endcase
      end
   end

`ifdef BLRAM_ARB_RR_EN
   logic rr_ptr;

   assign prio = rr_ptr;

   always_ff @(posedge clk) begin
      if (rst)
         rr_ptr <= PORT0;
      else if (win_valid && lock_owner == LOCK_NONE)
         rr_ptr <= ~win_id;
   end
`else
   assign prio = PORT0;
`endif

   arb2_pick u_pick (
      .req       (cand),
      .prio      (prio),
      .win_valid (win_valid),
      .win_id    (win_id)
   );

   assign sel_we    = (win_id == PORT1) ? bus.we1    : bus.we0;
   assign sel_lock  = (win_id == PORT1) ? bus.lock1  : bus.lock0;
   assign sel_addr  = (win_id == PORT1) ? bus.addr1  : bus.addr0;
   assign sel_wdata = (win_id == PORT1) ? bus.wdata1 : bus.wdata0;

   assign bus.gnt0      = win_valid && (win_id == PORT0);
   assign bus.gnt1      = win_valid && (win_id == PORT1);
   assign bus.mem_we    = win_valid && sel_we;
   assign bus.mem_addr  = win_valid ? sel_addr  : '0;
   assign bus.mem_wdata = win_valid ? sel_wdata : '0;

   // Read data is steered to whoever owned the grant one cycle earlier.
   assign bus.rvalid0 = !rst && rd_pend && (rd_id == PORT0);
   assign bus.rvalid1 = !rst && rd_pend && (rd_id == PORT1);
   assign bus.rdata0  = bus.mem_rdata;
   assign bus.rdata1  = bus.mem_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_owner <= LOCK_NONE;
         rd_pend    <= 1'b0;
         rd_id      <= PORT0;
      end else begin
         rd_pend <= win_valid && !sel_we;
         rd_id   <= win_id;
         case (lock_owner)
            LOCK_NONE: begin
               if (win_valid && sel_lock)
                  lock_owner <= (win_id == PORT1) ? LOCK_P1 : LOCK_P0;
            end
            LOCK_P0: begin
               if (!bus.lock0 || !bus.req0)
                  lock_owner <= LOCK_NONE;
            end
            LOCK_P1: begin
               if (!bus.lock1 || !bus.req1)
                  lock_owner <= LOCK_NONE;
            end
            default: lock_owner <= LOCK_NONE;
         endcase
      end
   end

endmodule
